digit_scanner: RTL and testbench

Time-multiplexed display scanner for the alarm clock's seven-segment display. It sits directly upstream of `decoder_8`. It walks a 3-bit digit index through the active digits and drives the decoder's select and enable inputs. It also presents the matching BCD nibble and decimal point to the segment encoder. A blanking interval at the start of every digit slot prevents ghosting. Input digits are snapshotted once per frame so a time update cannot tear a displayed frame.

---
 rtl/digit_scanner_pkg.sv | 27 ++
 rtl/digit_scanner_slot_timer.sv | 39 +++
 rtl/digit_scanner.sv | 147 ++++++++++++++
 tb/tb_digit_scanner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/digit_scanner_pkg.sv
// Shared types and constants for the seven-segment digit scanner: state
// encodings, bus widths and the snapshot record captured once per frame.
package digit_scanner_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int BCD_W      = 4;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    typedef logic [MAX_DIGITS*BCD_W-1:0] bcd_bus_t;
    typedef logic [IDX_W-1:0]            digit_idx_t;

    typedef struct packed {
        bcd_bus_t              digits;
        logic [MAX_DIGITS-1:0] dps;
    } snapshot_t;

    function automatic logic [BCD_W-1:0] digit_nibble(input bcd_bus_t bus, input digit_idx_t idx);
        return bus[idx*BCD_W +: BCD_W];
    endfunction

endpackage

// File: rtl/digit_scanner_slot_timer.sv
// Per-slot cycle counter: wraps every PRESCALE cycles and strobes on the last
// blanked cycle and on the last cycle of the slot.
module slot_timer #(
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic blank_done,
    output logic slot_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == SLOT_LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_done = (cnt_q == BLANK_LAST);
    assign slot_done  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed seven-segment scanner: walks the digit index, blanks the
// start of each slot and shows a per-frame snapshot of the input digits.
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int PRESCALE   = 1000,
    parameter int BLANK      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scan_en,
    input  logic [MAX_DIGITS*BCD_W-1:0] digits_in,
    input  logic [MAX_DIGITS-1:0]       dp_in,
    input  logic [MAX_DIGITS-1:0]       blank_mask,
    output logic [IDX_W-1:0]            sel,
    output logic                        enable,
    output logic [BCD_W-1:0]            bcd_out,
    output logic                        dp_out,
    output logic                        frame_tick
);

    localparam digit_idx_t IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    digit_idx_t       idx_q, idx_d;
    snapshot_t        snap_q, snap_d;
    digit_idx_t       sel_q, sel_d;
    logic             enable_q, enable_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;

    logic timer_clr;
    logic blank_done;
    logic slot_done;
    logic slot_start;
    logic frame_start;

    // Hold the timer at zero while dark so the first slot after a start is full length.
    assign timer_clr = (state_q == ST_IDLE) || !scan_en;

    slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (timer_clr),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        sel_d       = sel_q;
        bcd_d       = bcd_q;
        dp_d        = dp_q;
        tick_d      = 1'b0;
        slot_start  = 1'b0;
        frame_start = 1'b0;

        if (!scan_en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            sel_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d     = ST_BLANK;
                    idx_d       = '0;
                    frame_start = 1'b1;
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (slot_done) begin
                        state_d    = ST_BLANK;
                        slot_start = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    sel_d   = '0;
                end
            endcase
        end

        if (frame_start) begin
            snap_d.digits = digits_in;
            snap_d.dps    = dp_in;
            tick_d        = 1'b1;
        end

        // Display data is taken from snap_d so a new frame shows its fresh snapshot at once.
        if (frame_start || slot_start) begin
            sel_d = idx_d;
            bcd_d = digit_nibble(snap_d.digits, idx_d);
            dp_d  = snap_d.dps[idx_d];
        end

        enable_d = (state_d == ST_DRIVE) && !blank_mask[idx_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            // NOTE: the snapshot is reset like any other register; it is a few flops, not a RAM.
            snap_q   <= '0;
            sel_q    <= '0;
            enable_q <= 1'b0;
            bcd_q    <= '0;
            dp_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            bcd_q    <= bcd_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign enable     = enable_q;
    assign bcd_out    = bcd_q;
    assign dp_out     = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner: the stimulus side pushes the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_digit_scanner;

    localparam int ND    = 6;
    localparam int PS    = 4;
    localparam int BL    = 1;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_en;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_mask;
    logic [2:0]  sel;
    logic        enable;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic        frame_tick;

    always #5 clk = ~clk;

    digit_scanner #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PS),
        .BLANK      (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .sel        (sel),
        .enable     (enable),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic       en;
        logic [3:0] bcd;
        logic       dp;
        logic       tick;
        bit         chk_data;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int scan_c   = 0;
    bit running  = 1'b0;
    logic [31:0] mdl_digits = '0;
    logic [7:0]  mdl_dp     = '0;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one edge and push what the outputs must be right after it.
    // Position in the scan is tracked by a plain cycle count since the start.
    task automatic step();
        exp_t e;
        int   slot;
        int   phase;
        @(posedge clk);
        e.cyc      = cyc_n;
        cyc_n++;
        e.sel      = '0;
        e.en       = 1'b0;
        e.bcd      = '0;
        e.dp       = 1'b0;
        e.tick     = 1'b0;
        e.chk_data = 1'b1;
        if (reset) begin
            running = 1'b0;
        end else if (!scan_en) begin
            running    = 1'b0;
            e.chk_data = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                scan_c  = 0;
            end else begin
                scan_c++;
            end
            slot  = (scan_c / PS) % ND;
            phase = scan_c % PS;
            if (scan_c % FRAME == 0) begin
                mdl_digits = digits_in;
                mdl_dp     = dp_in;
                e.tick     = 1'b1;
            end
            e.sel = 3'(slot);
            e.en  = (phase >= BL) && !blank_mask[slot];
            e.bcd = mdl_digits[slot*4 +: 4];
            e.dp  = mdl_dp[slot];
        end
        exp_q.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                check("sel", m.cyc, 32'(sel), 32'(m.sel));
                check("enable", m.cyc, 32'(enable), 32'(m.en));
                check("frame_tick", m.cyc, 32'(frame_tick), 32'(m.tick));
                if (m.chk_data) begin
                    check("bcd_out", m.cyc, 32'(bcd_out), 32'(m.bcd));
                    check("dp_out", m.cyc, 32'(dp_out), 32'(m.dp));
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        scan_en    = 1'b1;
        digits_in  = 32'h0012_3456;
        dp_in      = 8'h2A;
        blank_mask = 8'h00;

        // Reset held 3 edges with scan_en high: everything stays dark.
        repeat (3) step();
        reset = 1'b0;

        // Frame 1: basic scan, digits 6,5,4,3,2,1.
        repeat (FRAME) step();

        // Frame 2: change digits during slot 2; the frame must not tear.
        repeat (2*PS + 2) step();
        digits_in = 32'h0099_9999;
        repeat (FRAME - (2*PS + 2)) step();

        // Frame 3: all 9s, with slot 2 masked.
        blank_mask = 8'b0000_0100;
        repeat (FRAME) step();
        blank_mask = 8'h00;

        // Frame 4: stop in the third cycle of slot 3.
        repeat (3*PS + 3) step();
        scan_en = 1'b0;
        repeat (3) step();

        // Restart: fresh snapshot with nibbles above 9, then the next frame tick.
        digits_in = 32'h00FE_DCBA;
        dp_in     = 8'h81;
        scan_en   = 1'b1;
        repeat (FRAME + 1) step();

        @(negedge clk);
        #1;
        check("queue_drained", cyc_n, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
